pwm_duty_meter: RTL and testbench

PWM_DUTY_METER -- requirements
Module: pwm_duty_meter

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_div4.sv | 62 ++++++
 rtl/pwm_duty_meter.sv | 126 ++++++++++++
 tb/tb_pwm_duty_meter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and FSM encoding for the PWM duty-cycle meter.
package pwm_pkg;

  localparam int unsigned DUTY_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_div4.sv
// Four-iteration restoring divider: quot = floor(dividend*16/divisor), dividend < divisor.
module pwm_div4
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [CNT_W-1:0]  dividend,
  input  logic [CNT_W-1:0]  divisor,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] quot
);

  localparam int unsigned STEP_W = $clog2(DUTY_W);

  logic [CNT_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_div;
  logic [DUTY_W-2:0] r_q;
  logic [STEP_W-1:0] r_step;
  logic              r_busy;

  logic [CNT_W:0]    w_shift;
  logic [CNT_W-1:0]  w_sub;
  logic              w_bit;

  // Remainder stays below the divisor, so the shifted value fits CNT_W+1 bits.
  always_comb begin
    w_shift = {r_rem, 1'b0};
    w_bit   = (w_shift >= {1'b0, r_div});
    w_sub   = w_bit ? (w_shift[CNT_W-1:0] - r_div) : w_shift[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_step <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_q    <= '0;
    end else if (load && !r_busy) begin
      r_busy <= 1'b1;
      r_step <= '0;
      r_rem  <= dividend;
      r_div  <= divisor;
      r_q    <= '0;
    end else if (r_busy) begin
      r_rem  <= w_sub;
      r_q    <= {r_q[DUTY_W-3:0], w_bit};
      r_step <= r_step + STEP_W'(1);
      if (r_step == STEP_W'(DUTY_W - 1)) r_busy <= 1'b0;
    end
  end

  // The last quotient bit is folded in combinationally so the caller can register it on this edge.
  assign busy = r_busy;
  assign done = r_busy && (r_step == STEP_W'(DUTY_W - 1));
  assign quot = {r_q, w_bit};

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high time, period and 4-bit duty of an asynchronous PWM input; flags stuck input and overruns.
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              stuck,
  output logic              stuck_level,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_s1, r_s2, r_s3;
  logic              w_edge;
  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_per, r_high;
  logic [CNT_W-1:0]  r_snap_high, r_snap_per;
  logic              w_snap, w_load, w_busy, w_done;
  logic [DUTY_W-1:0] w_quot;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= pwm_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_s3;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // An edge always wins over a simultaneous timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_edge) w_next = MEASURE;
      MEASURE: if (!w_edge && (r_per == CNT_MAX)) w_next = HOLD;
      HOLD:    if (w_edge) w_next = MEASURE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    stuck  = 1'b0;
    w_snap = 1'b0;
    case (r_state)
      MEASURE: w_snap = w_edge;
      HOLD:    stuck  = 1'b1;
      default: ;
    endcase
  end

  assign w_load = w_snap && !w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_per  <= '0;
      r_high <= '0;
    end else if (w_edge) begin
      r_per  <= CNT_W'(1);
      r_high <= CNT_W'(1);
    end else if ((r_state == MEASURE) && (w_next == MEASURE)) begin
      r_per  <= r_per + CNT_W'(1);
      r_high <= r_high + CNT_W'(r_s2);
    end else begin
      r_per  <= '0;
      r_high <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_high <= '0;
      r_snap_per  <= '0;
      high_cnt    <= '0;
      period_cnt  <= '0;
      duty        <= '0;
      valid       <= 1'b0;
      stuck_level <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      valid <= w_done;
      if (w_load) begin
        r_snap_high <= r_high;
        r_snap_per  <= r_per;
      end
      if (w_done) begin
        high_cnt   <= r_snap_high;
        period_cnt <= r_snap_per;
        duty       <= w_quot;
      end
      if (w_snap && w_busy) overrun <= 1'b1;
      if ((r_state == MEASURE) && (w_next == HOLD)) stuck_level <= r_s2;
    end
  end

  pwm_div4 #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .load    (w_load),
    .dividend(r_high),
    .divisor (r_per),
    .busy    (w_busy),
    .done    (w_done),
    .quot    (w_quot)
  );

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter with CNT_W=8.
module tb_pwm_duty_meter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] high_cnt, period_cnt;
  logic [3:0]   duty;
  logic         valid, stuck, stuck_level, overrun;

  typedef struct {
    logic [W-1:0] h;
    logic [W-1:0] p;
    logic [3:0]   d;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  pwm_duty_meter #(.CNT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .duty       (duty),
    .valid      (valid),
    .stuck      (stuck),
    .stuck_level(stuck_level),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: cycle %0d reached, required finish earlier", cyc);
    $fatal(1);
  end

  // Pops the oldest expected measurement whenever the DUT reports one.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: valid=1 at cycle %0d, required no valid", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_tests++;
        if (high_cnt !== e.h) begin
          n_fail++;
          $display("FAIL valid_high_cnt: got %0d, required %0d", high_cnt, e.h);
        end
        n_tests++;
        if (period_cnt !== e.p) begin
          n_fail++;
          $display("FAIL valid_period_cnt: got %0d, required %0d", period_cnt, e.p);
        end
        n_tests++;
        if (duty !== e.d) begin
          n_fail++;
          $display("FAIL valid_duty: got %0d, required %0d", duty, e.d);
        end
        n_tests++;
        if (cyc !== e.due) begin
          n_fail++;
          $display("FAIL valid_latency: valid at cycle %0d, required cycle %0d", cyc, e.due);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One PWM period starting with a rising pin edge; if acc, its measurement is expected.
  task automatic period(input int h, input int p, input bit acc);
    exp_t e;
    @(negedge clk);
    pwm_in = 1'b1;
    if (acc) begin
      e.h   = W'(h);
      e.p   = W'(p);
      e.d   = 4'((h * 16) / p);
      e.due = cyc + p + 7;
      sb.push_back(e);
    end
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (p - h - 1) @(negedge clk);
  endtask

  task automatic close_edge(input string name);
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (12) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_valid: %0d pending, required 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if ({high_cnt, period_cnt, duty, valid, stuck, stuck_level, overrun} !== '0) begin
      n_fail++;
      $display("FAIL %s: hc=%0d pc=%0d duty=%0d v=%b st=%b lvl=%b ovr=%b, required all 0",
               name, high_cnt, period_cnt, duty, valid, stuck, stuck_level, overrun);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_3_8();
    do_reset();
    repeat (4) period(3, 8, 1'b1);
    close_edge("wave_3_8");
  endtask

  task automatic test_duty_sweep();
    do_reset();
    for (int h = 1; h <= 15; h++) period(h, 16, 1'b1);
    period(7, 10, 1'b1);
    close_edge("duty_sweep");
  endtask

  task automatic test_stuck(input logic lvl);
    int n0;
    do_reset();
    period(3, 8, 1'b1);
    period(3, 8, 1'b1);
    @(negedge clk);
    pwm_in = 1'b1;
    n0 = cyc;
    if (!lvl) begin
      repeat (3) @(negedge clk);
      pwm_in = 1'b0;
    end
    while (cyc < n0 + 257) @(negedge clk);
    n_tests++;
    if (stuck !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_early: stuck=%b at cycle %0d, required 0", stuck, cyc);
    end
    @(negedge clk);
    n_tests++;
    if (stuck !== 1'b1 || stuck_level !== lvl) begin
      n_fail++;
      $display("FAIL stuck_set: stuck=%b level=%b, required 1 and %b", stuck, stuck_level, lvl);
    end
    n_tests++;
    if (high_cnt !== 8'd3 || period_cnt !== 8'd8 || duty !== 4'd6) begin
      n_fail++;
      $display("FAIL stuck_retain: hc=%0d pc=%0d duty=%0d, required 3 8 6", high_cnt, period_cnt, duty);
    end
    if (lvl) begin
      pwm_in = 1'b0;
      repeat (2) @(negedge clk);
    end
    period(3, 8, 1'b1);
    n_tests++;
    if (stuck !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_clear: stuck=%b, required 0", stuck);
    end
    close_edge(lvl ? "stuck_high" : "stuck_low");
  endtask

  task automatic test_overrun();
    do_reset();
    period(2, 4, 1'b1);
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_early: overrun=%b, required 0", overrun);
    end
    for (int i = 0; i < 5; i++) period(2, 4, (i % 2) == 1);
    close_edge("overrun");
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: overrun=%b, required 1", overrun);
    end
  endtask

  task automatic test_reset_mid_div();
    do_reset();
    period(3, 8, 1'b1);
    period(3, 8, 1'b0);
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (2) @(negedge clk);
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (high_cnt !== 8'd3 || period_cnt !== 8'd8 || duty !== 4'd6) begin
      n_fail++;
      $display("FAIL pre_reset_outputs: hc=%0d pc=%0d duty=%0d, required 3 8 6", high_cnt, period_cnt, duty);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("mid_div_reset_state");
    repeat (6) @(negedge clk);
    check_zero("mid_div_no_result");
    period(3, 8, 1'b1);
    close_edge("reset_mid_div");
  endtask

  initial begin
    test_reset();
    test_3_8();
    test_duty_sweep();
    test_stuck(1'b0);
    test_stuck(1'b1);
    test_overrun();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
